data_memory_responder: RTL and testbench

Word-addressed data memory that sits on the processor's data port and answers its load/store requests. Each request is latched, held for a parameterised number of wait cycles, then completed with a one-cycle `mem_ready` pulse. Read data is returned on `data_out`, and out-of-range or misaligned accesses are flagged. This is the responder the multi-cycle/stalling processor core will be built against.

---
 rtl/mem_pkg.sv | 17 +
 rtl/wait_counter.sv | 32 +++
 rtl/data_memory_responder.sv | 106 ++++++++++
 tb/tb_data_memory_responder.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the data memory responder.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int MEM_LATENCY_DEFAULT = 2;
    localparam int MEM_DEPTH_DEFAULT   = 256;

    function automatic logic [29:0] word_index(input logic [31:0] addr);
        return addr[31:2];
    endfunction

endpackage

// File: rtl/wait_counter.sv
// 4-bit loadable down-counter; saturates at zero and flags it.
module wait_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       dec,
    input  logic [3:0] load_val,
    output logic       zero
);

    logic [3:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != 4'd0)) begin
            count_d = count_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == 4'd0);

endmodule

// File: rtl/data_memory_responder.sv
// Word-addressed data memory answering one load/store at a time after LATENCY cycles.
// States: IDLE waits for a request | BUSY counts wait cycles | DONE pulses mem_ready.
module data_memory_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = MEM_DEPTH_DEFAULT,
    parameter int LATENCY     = MEM_LATENCY_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_in,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] data_out,
    output logic        mem_ready,
    output logic        mem_err
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    function automatic logic is_legal(input logic [31:0] addr);
        return (addr[1:0] == 2'b00) && ({2'b00, word_index(addr)} < 32'(DEPTH_WORDS));
    endfunction

    state_e      state_q, state_d;
    logic [31:0] req_addr_q, req_data_q;
    logic        req_wr_q, req_both_q;
    logic [31:0] data_out_q, data_out_d;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic        accept, cnt_zero, enter_done, rd_en;
    logic [31:0] rd_addr;

    assign accept = (state_q == ST_IDLE) && (mem_read || mem_write);

    wait_counter u_wait (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .dec      (state_q == ST_BUSY),
        .load_val (CNT_INIT),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = (LATENCY == 1) ? ST_DONE : ST_BUSY;
            ST_BUSY: if (cnt_zero) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // With LATENCY=1 DONE is entered on the accepting edge, before req_* hold the request.
    always_comb begin
        rd_addr    = (state_q == ST_IDLE) ? data_addr : req_addr_q;
        rd_en      = (state_q == ST_IDLE) ? !mem_write : !req_wr_q;
        enter_done = (state_q != ST_DONE) && (state_d == ST_DONE);
        data_out_d = data_out_q;
        if (enter_done && rd_en) begin
            data_out_d = is_legal(rd_addr) ? mem_q[rd_addr[IDX_W+1:2]] : 32'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_addr_q <= 32'd0;
            req_data_q <= 32'd0;
            req_wr_q   <= 1'b0;
            req_both_q <= 1'b0;
            data_out_q <= 32'd0;
        end else begin
            data_out_q <= data_out_d;
            if (accept) begin
                req_addr_q <= data_addr;
                req_data_q <= data_in;
                req_wr_q   <= mem_write;
                req_both_q <= mem_read && mem_write;
            end
        end
    end

    always_ff @(posedge clk) begin
        if ((state_q == ST_DONE) && req_wr_q && is_legal(req_addr_q)) begin
            mem_q[req_addr_q[IDX_W+1:2]] <= req_data_q;
        end
    end

    always_comb begin
        mem_ready = (state_q == ST_DONE);
        mem_err   = mem_ready && (req_both_q || !is_legal(req_addr_q));
        data_out  = data_out_q;
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed and randomized checks of the data memory responder against a word-array model.
module tb_data_memory_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr, din, dout;
    logic        rd, wr, rdy, err;
    logic [31:0] addr1, din1, dout1;
    logic        rd1, wr1, rdy1, err1;

    int tests = 0;
    int fails = 0;

    logic [31:0] ref_mem [DEPTH];
    bit          ref_def [DEPTH];
    logic [31:0] last_dout;
    bit          dout_known;

    always #5 clk = ~clk;

    data_memory_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .reset(rst_n), .data_addr(addr), .data_in(din),
        .mem_read(rd), .mem_write(wr), .data_out(dout), .mem_ready(rdy), .mem_err(err)
    );

    data_memory_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
        .clk(clk), .reset(rst_n), .data_addr(addr1), .data_in(din1),
        .mem_read(rd1), .mem_write(wr1), .data_out(dout1), .mem_ready(rdy1), .mem_err(err1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_legal(input logic [31:0] a);
        return (a % 4 == 0) && (a / 4 < DEPTH);
    endfunction

    // Called at a negedge with the responder idle; returns at the negedge after the pulse.
    task automatic access(input logic rd_i, input logic wr_i, input logic [31:0] a,
                          input logic [31:0] d, input string tag);
        int          n;
        int          idx;
        logic        got;
        logic        exp_err;
        logic [31:0] exp_dout;
        bit          chk_dout;
        exp_err  = (rd_i && wr_i) || !ref_legal(a);
        idx      = ref_legal(a) ? int'(a / 4) : 0;
        exp_dout = 32'd0;
        chk_dout = 1'b1;
        if (wr_i) begin
            chk_dout = dout_known;
            exp_dout = last_dout;
            if (ref_legal(a)) begin
                ref_mem[idx] = d;
                ref_def[idx] = 1'b1;
            end
        end else if (!ref_legal(a)) begin
            last_dout  = 32'd0;
            dout_known = 1'b1;
        end else begin
            chk_dout   = ref_def[idx];
            exp_dout   = ref_mem[idx];
            last_dout  = exp_dout;
            dout_known = ref_def[idx];
        end
        addr = a; din = d; rd = rd_i; wr = wr_i;
        @(posedge clk);
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (rdy === 1'b1) got = 1'b1;
        end
        check({tag, " latency"}, 32'(n), 32'(LAT));
        if (got) begin
            check({tag, " err"}, {31'd0, err}, {31'd0, exp_err});
            if (chk_dout) check({tag, " data_out"}, dout, exp_dout);
        end
        rd = 1'b0; wr = 1'b0;
        @(negedge clk);
        check({tag, " ready pulse width"}, {31'd0, rdy}, 32'd0);
        check({tag, " err idle"}, {31'd0, err}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int r, k;
        logic [31:0] a;
        rst_n = 1'b0;
        addr = 0; din = 0; rd = 0; wr = 0;
        addr1 = 0; din1 = 0; rd1 = 0; wr1 = 0;
        last_dout = 32'd0; dout_known = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin ref_mem[i] = 32'd0; ref_def[i] = 1'b0; end
        repeat (3) @(negedge clk);
        check("reset mem_ready", {31'd0, rdy}, 32'd0);
        check("reset mem_err", {31'd0, err}, 32'd0);
        check("reset data_out", dout, 32'd0);
        check("reset l1 mem_ready", {31'd0, rdy1}, 32'd0);
        rst_n = 1'b1;

        access(0, 1, 32'h10, 32'h0, "wr 0x10");
        access(1, 0, 32'h10, 32'h0, "rd 0x10");
        access(0, 1, 32'h04, 32'hDEADBEEF, "wr 0x04");
        access(1, 0, 32'h04, 32'h0, "rd 0x04");
        access(1, 0, 32'h06, 32'h0, "rd misaligned");
        access(1, 0, 32'h04, 32'h0, "rd 0x04 again");
        access(1, 0, 32'h400, 32'h0, "rd out of range");
        access(0, 1, 32'h00, 32'h77, "wr 0x00");
        access(0, 1, 32'h400, 32'h55, "wr out of range");
        access(1, 0, 32'h00, 32'h0, "rd 0x00");
        access(1, 1, 32'h08, 32'h1234, "both ops 0x08");
        access(1, 0, 32'h08, 32'h0, "rd 0x08");

        access(0, 1, 32'h0C, 32'h1111, "wr 0x0C");
        addr = 32'h0C; din = 32'hAAAA; wr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1 check("reset mid-write ready", {31'd0, rdy}, 32'd0);
        wr = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("reset mid-write ready held", {31'd0, rdy}, 32'd0);
        end
        rst_n = 1'b1;
        last_dout = 32'd0; dout_known = 1'b1;
        check("data_out after reset", dout, 32'd0);
        access(1, 0, 32'h0C, 32'h0, "rd 0x0C after abort");

        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       a = 32'($urandom_range(0, 15)) * 4;
            else if (r == 7) a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
            else if (r == 8) a = 32'h400 + 32'($urandom_range(0, 255)) * 4;
            else             a = $urandom | 32'h8000_0000;
            k = $urandom_range(0, 4);
            access(k < 2 || k == 4, k >= 2, a, $urandom, "random");
        end

        addr1 = 32'h0; din1 = 32'hCAFEF00D; wr1 = 1'b1;
        @(posedge clk);
        #1 check("l1 write ready", {31'd0, rdy1}, 32'd1);
        check("l1 write err", {31'd0, err1}, 32'd0);
        @(negedge clk);
        wr1 = 1'b0;
        @(negedge clk);
        check("l1 write ready width", {31'd0, rdy1}, 32'd0);
        rd1 = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("l1 b2b ready", {31'd0, rdy1}, (i % 2 == 0) ? 32'd1 : 32'd0);
            if (rdy1 === 1'b1) begin
                pulses++;
                check("l1 b2b data_out", dout1, 32'hCAFEF00D);
                check("l1 b2b err", {31'd0, err1}, 32'd0);
            end
        end
        rd1 = 1'b0;
        check("l1 b2b completions", 32'(pulses), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
